dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 0, extra stall cycles (0..15) inserted before every SRAM access.
REQ-002 SHALL have parameter SRAM_ADDR_BITS, default 14, word-address width of the backing SRAM.
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-004 SHALL have ports D_req input 1 (read request, held high until the cache sees its last beat); D_write input 1 (write request, held until done); D_addr input 32 (byte address); D_in input 32 (write data); D_type input 4 (active-low byte write enables, bit i = byte i).
REQ-005 SHALL have ports D_out output 32 (read beat data) and D_wait output 1 (1 = busy/no beat, 0 = beat valid or write done).
REQ-006 SHALL have SRAM ports sram_CS output 1, sram_OE output 1, sram_WEB output 4 (active low), sram_A output SRAM_ADDR_BITS, sram_DI output 32, sram_DO input 32 (valid one cycle after a read issue).

Function
REQ-007 SHALL implement states IDLE, STALL, RD_ISSUE, RD_DATA, WR, GAP.
REQ-008 IDLE: D_write=1 SHALL take priority over D_req=1; either SHALL latch D_addr, D_in, D_type, clear beat counter and stall counter, go to STALL if WAIT_CYCLES>0, else to RD_ISSUE (read) or WR (write).
REQ-009 STALL SHALL last exactly WAIT_CYCLES cycles, then enter RD_ISSUE or WR per the latched operation.
REQ-010 Burst length SHALL be 1 when latched addr[31:16] is 16'h1000, 16'h0010 or 16'h0003 (non-cacheable), else 4.
REQ-011 Burst base address SHALL be {addr[31:4],4'h0} for length 4; beat k address {addr[31:4],k[1:0],2'b00}; for length 1 the exact word addr[31:2]; no carry into addr[31:4].
REQ-012 RD_ISSUE SHALL drive sram_CS=1, sram_OE=1, sram_WEB=4'hf, sram_A=beat word address[SRAM_ADDR_BITS+1:2] (upper bits ignored), then go to RD_DATA.
REQ-013 RD_DATA SHALL drive D_wait=0 and D_out=sram_DO for exactly one cycle; if last beat go to GAP, else increment beat and go to STALL (WAIT_CYCLES>0) or RD_ISSUE.
REQ-014 WR SHALL drive sram_CS=1, sram_OE=0, sram_WEB=latched D_type, sram_DI=latched D_in, sram_A=latched word address, D_wait=0 for one cycle, then go to GAP.
REQ-015 D_type=4'hf write SHALL complete the handshake with no byte modified.
REQ-016 GAP SHALL last one cycle with D_wait=1, ignore D_req/D_write, then return to IDLE (absorbs the cache's one-cycle-late request drop).
REQ-017 D_wait SHALL be 1 in all states except RD_DATA and WR.
REQ-018 Outside RD_DATA, D_out SHALL hold the last returned beat (hold register).
REQ-019 In all states other than RD_ISSUE and WR, sram_CS=0, sram_OE=0, sram_WEB=4'hf.
REQ-020 Read latency (WAIT_CYCLES=0): request sampled in IDLE at cycle T -> beats at T+2, T+4, T+6, T+8; GAP T+9; IDLE T+10. Each beat adds 2+WAIT_CYCLES cycles.
REQ-021 Write latency (WAIT_CYCLES=0): sampled at T -> D_wait=0 and SRAM write at T+1, GAP T+2.
REQ-022 Requests dropped mid-burst SHALL NOT abort the transaction; the burst completes to GAP.

Reset
REQ-023 While rst=1, state SHALL be IDLE next cycle; D_wait=1, D_out hold=32'h0, counters 0, latched fields 0.
REQ-024 While rst=1, sram_CS=0, sram_OE=0 and sram_WEB=4'hf combinationally, so reset in WR or RD_ISSUE causes no SRAM access.
REQ-025 Reset mid-burst SHALL discard remaining beats; first post-reset request is served normally.

Verification
REQ-026 Line fill: D_req=1, D_addr=32'h0000_1234, SRAM words 0x48C..0x48F = A0,A1,A2,A3 -> D_wait=0 at T+2/4/6/8 with D_out A0..A3, sram_A 0x48C..0x48F.
REQ-027 Non-cacheable read: D_addr=32'h1000_0008 -> single beat at T+2 of SRAM word 0x0002, GAP at T+3.
REQ-028 Byte write: D_write=1, D_addr=32'h0000_0010, D_in=32'hAABB_CCDD, D_type=4'b1100 over word 32'h1122_3344 -> D_wait=0 at T+1, word becomes 32'h1122_CCDD.
REQ-029 Simultaneous D_req and D_write in IDLE -> write served first; D_req still high after GAP starts a line fill.
REQ-030 WAIT_CYCLES=3 line fill -> beats at T+5, T+10, T+15, T+20; D_wait=1 between.
REQ-031 rst asserted during WR at T+1 -> sram_WEB=4'hf that cycle, memory unchanged, D_wait=1, IDLE next.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-side SRAM responder: 4-beat line fills (1 beat for non-cacheable windows) and single writes.
// Read beats every 2+WAIT_CYCLES cycles, write done 1+WAIT_CYCLES after accept; D_wait=1 whenever no beat/write completes.
module dmem_responder #(
    parameter int WAIT_CYCLES    = 0,
    parameter int SRAM_ADDR_BITS = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      D_req,
    input  logic                      D_write,
    input  logic [31:0]               D_addr,
    input  logic [31:0]               D_in,
    input  logic [3:0]                D_type,
    output logic [31:0]               D_out,
    output logic                      D_wait,
    output logic                      sram_CS,
    output logic                      sram_OE,
    output logic [3:0]                sram_WEB,
    output logic [SRAM_ADDR_BITS-1:0] sram_A,
    output logic [31:0]               sram_DI,
    input  logic [31:0]               sram_DO
);

    typedef enum logic [2:0] {
        IDLE,
        STALL,
        RD_ISSUE,
        RD_DATA,
        WR,
        GAP
    } state_t;

    localparam logic [3:0] STALL_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] din_q,   din_d;
    logic [3:0]  type_q,  type_d;
    logic        wr_q,    wr_d;
    logic [1:0]  beat_q,  beat_d;
    logic [3:0]  stall_q, stall_d;
    logic [31:0] dout_q,  dout_d;

    logic        single;
    logic        last_beat;
    logic [29:0] word_addr;
    logic        unused_addr_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            din_q   <= 32'h0;
            type_q  <= 4'h0;
            wr_q    <= 1'b0;
            beat_q  <= 2'd0;
            stall_q <= 4'd0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            type_q  <= type_d;
            wr_q    <= wr_d;
            beat_q  <= beat_d;
            stall_q <= stall_d;
            dout_q  <= dout_d;
        end
    end

    // Non-cacheable windows return a single exact word; everything else wraps inside its 16-byte line.
    assign single    = (addr_q[31:16] == 16'h1000) || (addr_q[31:16] == 16'h0010) ||
                       (addr_q[31:16] == 16'h0003);
    assign last_beat = single || (beat_q == 2'd3);
    assign word_addr = single ? addr_q[31:2] : {addr_q[31:4], beat_q};
    assign unused_addr_bits = ^{addr_q[1:0], word_addr[29:SRAM_ADDR_BITS]};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        din_d    = din_q;
        type_d   = type_q;
        wr_d     = wr_q;
        beat_d   = beat_q;
        stall_d  = stall_q;
        dout_d   = dout_q;
        D_out    = dout_q;
        D_wait   = 1'b1;
        sram_CS  = 1'b0;
        sram_OE  = 1'b0;
        sram_WEB = 4'hf;
        sram_A   = word_addr[SRAM_ADDR_BITS-1:0];
        sram_DI  = din_q;

        case (state_q)
            IDLE: begin
                if (D_write || D_req) begin
                    addr_d  = D_addr;
                    din_d   = D_in;
                    type_d  = D_type;
                    wr_d    = D_write;
                    beat_d  = 2'd0;
                    stall_d = 4'd0;
                    if (WAIT_CYCLES > 0) state_d = STALL;
                    else                 state_d = D_write ? WR : RD_ISSUE;
                end
            end
            STALL: begin
                if (stall_q == STALL_LAST) begin
                    stall_d = 4'd0;
                    state_d = wr_q ? WR : RD_ISSUE;
                end else begin
                    stall_d = stall_q + 4'd1;
                end
            end
            RD_ISSUE: begin
                sram_CS  = 1'b1;
                sram_OE  = 1'b1;
                state_d  = RD_DATA;
            end
            RD_DATA: begin
                D_wait = 1'b0;
                D_out  = sram_DO;
                dout_d = sram_DO;
                if (last_beat) begin
                    state_d = GAP;
                end else begin
                    beat_d  = beat_q + 2'd1;
                    stall_d = 4'd0;
                    state_d = (WAIT_CYCLES > 0) ? STALL : RD_ISSUE;
                end
            end
            WR: begin
                sram_CS  = 1'b1;
                sram_WEB = type_q;
                sram_A   = addr_q[SRAM_ADDR_BITS+1:2];
                D_wait   = 1'b0;
                state_d  = GAP;
            end
            GAP: begin
                // Swallows the request the cache is still holding for one cycle after its last beat.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            sram_CS  = 1'b0;
            sram_OE  = 1'b0;
            sram_WEB = 4'hf;
            D_wait   = 1'b1;
        end
    end

endmodule
